// File: rtl/jtcps1_dma_if.sv
// jtcps1_dma_if - bundle of every signal the CPS-A DMA block exchanges with
// the outside world: CPU register-write port, vertical blank, the 68000 bus
// handshake, the VRAM read port, the video buffer write port and the
// latched PPU registers.
//   master : the DMA block (drives busreq, VRAM request, buffer writes, regs)
//   slave  : the surrounding system (CPU, bus arbiter, VRAM, buffers)
interface jtcps1_dma_if;
    // CPU register window
    logic        cpu_cen;
    logic        ppu1_cs;
    logic [4:0]  addr;
    logic [15:0] cpu_dout;
    logic        UDSWn;
    logic        LDSWn;
    logic        LVBL;
    // 68000 bus handshake
    logic        busreq;
    logic        busack;
    // VRAM read port
    logic [16:0] vram_addr;
    logic        vram_cs;
    logic [15:0] vram_data;
    logic        vram_ok;
    // video buffer write port
    logic        buf_we;
    logic        buf_sel;
    logic [11:0] buf_addr;
    logic [15:0] buf_data;
    // PPU registers
    logic [15:0] obj_base, scr1_base, scr2_base, scr3_base, row_base, pal_base;
    logic [15:0] scr1_x, scr1_y, scr2_x, scr2_y, scr3_x, scr3_y;

    modport master (
        input  cpu_cen, ppu1_cs, addr, cpu_dout, UDSWn, LDSWn, LVBL,
        input  busack, vram_data, vram_ok,
        output busreq, vram_addr, vram_cs,
        output buf_we, buf_sel, buf_addr, buf_data,
        output obj_base, scr1_base, scr2_base, scr3_base, row_base, pal_base,
        output scr1_x, scr1_y, scr2_x, scr2_y, scr3_x, scr3_y
    );

    modport slave (
        output cpu_cen, ppu1_cs, addr, cpu_dout, UDSWn, LDSWn, LVBL,
        output busack, vram_data, vram_ok,
        input  busreq, vram_addr, vram_cs,
        input  buf_we, buf_sel, buf_addr, buf_data,
        input  obj_base, scr1_base, scr2_base, scr3_base, row_base, pal_base,
        input  scr1_x, scr1_y, scr2_x, scr2_y, scr3_x, scr3_y
    );
endinterface

// File: rtl/jtcps1_dma.sv
// jtcps1_dma - CPS-A register file and frame DMA engine.
// Latches CPU writes to the PPU register window and, once per frame (LVBL
// falling) or on a palette-base write, takes the 68000 bus and copies the
// object table / palette from VRAM into the internal video buffers.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - jtcps1_dma_if.master: CPU writes, LVBL, busreq/busack, VRAM read
//          port, buffer write port and the twelve PPU registers
module jtcps1_dma #(
    parameter int OBJ_LEN = 1024,   // words per object-table copy
    parameter int PAL_LEN = 3072    // words per palette copy
) (
    input  logic          clk,
    input  logic          rst,
    jtcps1_dma_if.master  bus
);
    typedef enum logic [2:0] {IDLE, REQ, ADDR, WAIT, REL} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_regs [12];
    logic        r_lvbl_l, r_obj_pend, r_pal_pend, r_sel;
    logic [16:0] r_src;
    logic [11:0] r_cnt;
    logic        r_buf_we, r_buf_sel;
    logic [11:0] r_buf_addr;
    logic [15:0] r_buf_data;

    logic        w_wr, w_pal_wr, w_lvbl_fall, w_last;
    logic        w_start, w_latch, w_busreq, w_vram_cs;
    logic [15:0] w_base;
    logic [11:0] w_len_m1;

    assign w_wr        = bus.cpu_cen & bus.ppu1_cs & (~bus.UDSWn | ~bus.LDSWn);
    assign w_pal_wr    = w_wr && (bus.addr == 5'd5);
    assign w_lvbl_fall = r_lvbl_l & ~bus.LVBL;
    assign w_base      = r_obj_pend ? r_regs[0] : r_regs[5];
    assign w_len_m1    = r_sel ? 12'(PAL_LEN - 1) : 12'(OBJ_LEN - 1);
    assign w_last      = (r_cnt == w_len_m1);

    // Register file, one byte lane at a time; indices 12-31 fall through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 12; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (w_wr && bus.addr == 5'(i)) begin
                    if (!bus.UDSWn) r_regs[i][15:8] <= bus.cpu_dout[15:8];
                    if (!bus.LDSWn) r_regs[i][7:0]  <= bus.cpu_dout[7:0];
                end
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_busreq  = 1'b0;
        w_vram_cs = 1'b0;
        w_start   = 1'b0;
        w_latch   = 1'b0;
        case (r_state)
            IDLE: if (r_obj_pend || r_pal_pend) begin
                w_next  = REQ;
                w_start = 1'b1;
            end
            REQ: begin
                w_busreq = 1'b1;
                if (bus.busack) w_next = ADDR;
            end
            ADDR: begin
                // vram_ok is ignored here: it may still belong to the
                // previous word.
                w_busreq = 1'b1;
                if (bus.busack) begin
                    w_vram_cs = 1'b1;
                    w_next    = WAIT;
                end
            end
            WAIT: begin
                w_busreq = 1'b1;
                if (!bus.busack) begin
                    // Grant lost: park in ADDR so the same word is re-read
                    // once the bus returns, behind the stale-ok guard.
                    w_next = ADDR;
                end else begin
                    w_vram_cs = 1'b1;
                    if (bus.vram_ok) begin
                        w_latch = 1'b1;
                        w_next  = w_last ? REL : ADDR;
                    end
                end
            end
            REL: if (!bus.busack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lvbl_l   <= 1'b0;
            r_obj_pend <= 1'b0;
            r_pal_pend <= 1'b0;
            r_sel      <= 1'b0;
            r_src      <= '0;
            r_cnt      <= '0;
            r_buf_we   <= 1'b0;
            r_buf_sel  <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
        end else begin
            r_state  <= w_next;
            r_lvbl_l <= bus.LVBL;
            r_buf_we <= 1'b0;
            // A new request in the same clk as the clear wins, so it is
            // served by a later transfer.
            r_obj_pend <= w_lvbl_fall | (r_obj_pend & ~w_start);
            r_pal_pend <= w_pal_wr | (r_pal_pend & ~(w_start & ~r_obj_pend));
            if (w_start) begin
                r_sel <= ~r_obj_pend;
                r_src <= {w_base[9:0], 7'd0};
                r_cnt <= '0;
            end
            if (w_latch) begin
                r_buf_we   <= 1'b1;
                r_buf_sel  <= r_sel;
                r_buf_addr <= r_cnt;
                r_buf_data <= bus.vram_data;
                if (!w_last) r_cnt <= r_cnt + 12'd1;
            end
        end
    end

    assign bus.busreq    = w_busreq;
    assign bus.vram_cs   = w_vram_cs;
    assign bus.vram_addr = r_src + {5'd0, r_cnt};
    assign bus.buf_we    = r_buf_we;
    assign bus.buf_sel   = r_buf_sel;
    assign bus.buf_addr  = r_buf_addr;
    assign bus.buf_data  = r_buf_data;

    assign bus.obj_base  = r_regs[0];
    assign bus.scr1_base = r_regs[1];
    assign bus.scr2_base = r_regs[2];
    assign bus.scr3_base = r_regs[3];
    assign bus.row_base  = r_regs[4];
    assign bus.pal_base  = r_regs[5];
    assign bus.scr1_x    = r_regs[6];
    assign bus.scr1_y    = r_regs[7];
    assign bus.scr2_x    = r_regs[8];
    assign bus.scr2_y    = r_regs[9];
    assign bus.scr3_x    = r_regs[10];
    assign bus.scr3_y    = r_regs[11];
endmodule

// File: tb/tb_jtcps1_dma.sv
// tb_jtcps1_dma - directed bench for jtcps1_dma with a scoreboard on the
// buffer write port, a VRAM model with programmable ok latency and a bus
// arbiter that grants 5 clks after a request.
module tb_jtcps1_dma;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtcps1_dma_if bus();
    jtcps1_dma #(.OBJ_LEN(1024), .PAL_LEN(3072)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // VRAM contents: an address-derived pattern, distinct per word.
    function automatic logic [15:0] mem(input logic [16:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C ^ {15'd0, a[16]};
    endfunction
    assign bus.vram_data = mem(bus.vram_addr);

    // VRAM responder: ok two clks after a new address is requested, or
    // permanently high in stale mode.
    bit ok_always = 0;
    initial begin
        logic [16:0] last;
        int dcnt;
        last = '1;
        dcnt = 0;
        bus.vram_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (ok_always) bus.vram_ok = 1'b1;
            else if (!bus.vram_cs || bus.vram_addr != last) begin
                dcnt = 0;
                bus.vram_ok = 1'b0;
                last = bus.vram_addr;
            end else if (dcnt < 2) begin
                dcnt++;
                bus.vram_ok = (dcnt == 2);
            end
        end
    end

    // Bus arbiter: grant 5 clks after busreq, release when busreq drops.
    bit hold_off = 0;
    initial begin
        int gcnt;
        gcnt = 0;
        bus.busack = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_off) begin
                bus.busack = 1'b0;
                gcnt = 0;
            end else if (bus.busreq && !bus.busack) begin
                gcnt++;
                if (gcnt >= 5) begin
                    bus.busack = 1'b1;
                    gcnt = 0;
                end
            end else if (!bus.busreq && bus.busack) begin
                bus.busack = 1'b0;
            end else begin
                gcnt = 0;
            end
        end
    end

    // Scoreboard monitor: {sel, addr, data} per buffer write.
    logic [28:0] exp_q[$];
    logic [28:0] sb_e;
    int cnt_sel[2];
    int cyc = 0;
    int first_we = -1;
    int last_we  = 0;
    bit expect_none = 0;

    initial begin
        cnt_sel[0] = 0;
        cnt_sel[1] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.buf_we) begin
                if (expect_none) chk("we_after_reset", bus.buf_we, 1'b0);
                else begin
                    chk("sb_q_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        sb_e = exp_q.pop_front();
                        chk("sb_word", {bus.buf_sel, bus.buf_addr, bus.buf_data}, sb_e);
                    end
                end
                cnt_sel[bus.buf_sel]++;
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
            end
        end
    end

    task automatic cpu_wr(input logic [4:0] a, input logic [15:0] d, input logic u, input logic l);
        @(negedge clk);
        bus.cpu_cen = 1'b1; bus.ppu1_cs = 1'b1; bus.addr = a; bus.cpu_dout = d;
        bus.UDSWn = u; bus.LDSWn = l;
        @(negedge clk);
        bus.cpu_cen = 1'b0; bus.ppu1_cs = 1'b0; bus.UDSWn = 1'b1; bus.LDSWn = 1'b1;
    endtask

    initial begin
        bus.cpu_cen = 1'b0; bus.ppu1_cs = 1'b0; bus.addr = '0; bus.cpu_dout = '0;
        bus.UDSWn = 1'b1; bus.LDSWn = 1'b1; bus.LVBL = 1'b1;

        // reset state
        #12;
        chk("rst_busreq", bus.busreq, 0);
        chk("rst_vram_cs", bus.vram_cs, 0);
        chk("rst_buf_we", bus.buf_we, 0);
        chk("rst_vram_addr", bus.vram_addr, 0);
        chk("rst_obj_base", bus.obj_base, 0);
        @(negedge clk); rst = 1'b0;

        // byte lanes
        cpu_wr(5'd6, 16'h1234, 1'b1, 1'b0);
        chk("lane_lo", bus.scr1_x, 16'h0034);
        cpu_wr(5'd6, 16'hABCD, 1'b0, 1'b0);
        chk("lane_full", bus.scr1_x, 16'hABCD);
        cpu_wr(5'd7, 16'h1234, 1'b0, 1'b1);
        chk("lane_hi", bus.scr1_y, 16'h1200);
        cpu_wr(5'd12, 16'hFFFF, 1'b0, 1'b0);
        chk("addr12_obj", bus.obj_base, 16'h0000);
        chk("addr12_scr1x", bus.scr1_x, 16'hABCD);
        chk("addr12_scr3y", bus.scr3_y, 16'h0000);
        chk("no_dma_idle", bus.busreq, 0);

        // object DMA, palette base written mid-transfer
        cpu_wr(5'd0, 16'h9000, 1'b0, 1'b0);
        chk("obj_base", bus.obj_base, 16'h9000);
        for (int i = 0; i < 1024; i++) exp_q.push_back({1'b0, 12'(i), mem(17'(i))});
        @(negedge clk); bus.LVBL = 1'b0;
        for (int n = 0; n < 50 && !bus.vram_cs; n++) @(negedge clk);
        chk("obj_cs_seen", bus.vram_cs, 1);
        chk("obj_first_addr", bus.vram_addr, 17'h00000);
        bus.LVBL = 1'b1;
        for (int n = 0; n < 5000 && cnt_sel[0] < 500; n++) @(negedge clk);
        cpu_wr(5'd5, 16'h9014, 1'b0, 1'b0);
        for (int i = 0; i < 3072; i++) exp_q.push_back({1'b1, 12'(i), mem(17'h00A00 + 17'(i))});
        for (int n = 0; n < 5000 && cnt_sel[0] < 1024; n++) @(negedge clk);
        chk("obj_count", cnt_sel[0], 1024);
        for (int n = 0; n < 50 && bus.busreq; n++) @(negedge clk);
        chk("busreq_gap", bus.busreq, 0);
        for (int n = 0; n < 50 && !bus.vram_cs; n++) @(negedge clk);
        chk("pal_cs_seen", bus.vram_cs, 1);
        chk("pal_first_addr", bus.vram_addr, 17'h00A00);
        chk("obj_count_final", cnt_sel[0], 1024);

        // grant drop mid-palette
        for (int n = 0; n < 5000 && cnt_sel[1] < 1000; n++) @(negedge clk);
        hold_off = 1;
        @(negedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            chk("gap_vram_cs", bus.vram_cs, 0);
            @(negedge clk); #1;
        end
        hold_off = 0;
        for (int n = 0; n < 15000 && cnt_sel[1] < 3072; n++) @(negedge clk);
        chk("pal_count", cnt_sel[1], 3072);
        for (int n = 0; n < 50 && bus.busreq; n++) @(negedge clk);
        chk("pal_busreq_drop", bus.busreq, 0);
        chk("sb_drained_pal", exp_q.size(), 0);

        // stale ok: one word per ADDR+WAIT pair
        ok_always = 1;
        first_we = -1;
        cpu_wr(5'd5, 16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 3072; i++) exp_q.push_back({1'b1, 12'(i), mem(17'h00080 + 17'(i))});
        for (int n = 0; n < 10000 && cnt_sel[1] < 6144; n++) @(negedge clk);
        chk("stale_count", cnt_sel[1], 6144);
        chk("stale_rate", last_we - first_we, 2 * 3071);
        chk("sb_drained_stale", exp_q.size(), 0);
        ok_always = 0;
        for (int n = 0; n < 50 && bus.busreq; n++) @(negedge clk);

        // reset during WAIT
        for (int i = 0; i < 1024; i++) exp_q.push_back({1'b0, 12'(i), mem(17'(i))});
        @(negedge clk); bus.LVBL = 1'b0;
        @(negedge clk); bus.LVBL = 1'b1;
        for (int n = 0; n < 2000 && !(bus.buf_we && cnt_sel[0] >= 1033); n++) @(negedge clk);
        @(posedge clk); #3;
        chk("pre_rst_cs", bus.vram_cs, 1);
        rst = 1'b1;
        #1;
        chk("arst_busreq", bus.busreq, 0);
        chk("arst_vram_cs", bus.vram_cs, 0);
        chk("arst_buf_we", bus.buf_we, 0);
        chk("arst_vram_addr", bus.vram_addr, 0);
        chk("arst_buf_addr", bus.buf_addr, 0);
        chk("arst_buf_data", bus.buf_data, 0);
        chk("arst_pal_base", bus.pal_base, 0);
        exp_q.delete();
        expect_none = 1;
        @(negedge clk); rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_rst_idle", bus.busreq, 0);
        expect_none = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/jtcps1_dma.md
Name: jtcps1_dma

Overview:
- CPS-A register file and frame DMA engine, directly downstream of the 68000 main CPU block.
- Latches the CPU writes that address the PPU register window: object, scroll and palette bases, and scroll offsets.
- Takes the 68000 bus with a busreq/busack handshake and copies the object table and palette from VRAM into the internal video buffers.

Parameters:
OBJ_LEN, 1024, words copied per object-table transfer (256 objects x 4 words)
PAL_LEN, 3072, words copied per palette transfer (6 pages x 512)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
cpu_cen  input  1  CPU clock enable; register writes sampled only when high
ppu1_cs  input  1  CPU write strobe for the PPU register window
addr  input  5  CPU word address A[5:1] inside the window
cpu_dout  input  16  CPU write data
UDSWn  input  1  upper byte write strobe, active low
LDSWn  input  1  lower byte write strobe, active low
LVBL  input  1  vertical blank, active low
busreq  output  1  bus request to the main CPU block
busack  input  1  bus granted
vram_addr  output  17  VRAM word address [17:1]
vram_cs  output  1  VRAM read request
vram_data  input  16  VRAM read data
vram_ok  input  1  VRAM data valid
buf_we  output  1  buffer write strobe, one clk wide
buf_sel  output  1  0 = object buffer, 1 = palette buffer
buf_addr  output  12  buffer word address
buf_data  output  16  buffer write data
obj_base, scr1_base, scr2_base, scr3_base, row_base, pal_base  output  16 each  base registers
scr1_x, scr1_y, scr2_x, scr2_y, scr3_x, scr3_y  output  16 each  scroll registers

Behaviour:
- Reset: all registers 0; busreq=0, vram_cs=0, buf_we=0; vram_addr, buf_addr and buf_data 0; state IDLE; pending flags cleared. Reset mid-transfer aborts immediately and busreq drops asynchronously.
- Register write condition: cpu_cen & ppu1_cs & (!UDSWn | !LDSWn). Each byte lane updates independently.
- Register map by addr: 0 obj_base, 1 scr1_base, 2 scr2_base, 3 scr3_base, 4 row_base, 5 pal_base, 6 scr1_x, 7 scr1_y, 8 scr2_x, 9 scr2_y, 10 scr3_x, 11 scr3_y. Indices 12-31 are ignored.
- Pending flags:
  - obj_pend is set on the falling edge of LVBL (compare against the previous-clk sample).
  - pal_pend is set on any write to addr 5, including a write during a transfer.
  - A flag clears only when its transfer enters REQ.
- Source address: vram_addr = {pal_base or obj_base}[9:0]*128 + cnt, truncated to 17 bits; wrap-around is silent. The base register is sampled at REQ entry, so later writes do not affect a running transfer.
- States:
  - IDLE: if obj_pend, select obj (priority); otherwise if pal_pend, select pal. Go to REQ; cnt=0.
  - REQ: busreq=1; wait for busack=1, then go to ADDR.
  - ADDR: drive vram_addr with vram_cs=1 for one clk, ignoring vram_ok (stale-ok guard); go to WAIT.
  - WAIT: hold vram_cs=1. On vram_ok=1, latch buf_data=vram_data, buf_addr=cnt[11:0], buf_sel, and pulse buf_we on the next clk. If cnt==LEN-1 go to REL; otherwise cnt+1 and go to ADDR.
  - REL: vram_cs=0, busreq=0; wait for busack=0, then go to IDLE.
- busack dropping before REQ's grant or during ADDR/WAIT: hold state with vram_cs=0 until busack returns; no word is skipped or duplicated.
- Back-to-back transfers: a pending palette runs after the object transfer. Each transfer goes through REL and IDLE, so busreq drops for at least one clk between them.
- Latency: request to first buf_we = 3 clks after busack, plus the vram_ok delay.

Test Plan:
- Reset mid-WAIT: all outputs return to 0 within the reset cycle; after release the state is IDLE and no buf_we is issued.
- Byte lanes: writing 0x1234 to addr 6 with only LDSWn low leaves scr1_x=0x0034; a following full write of 0xABCD gives 0xABCD. A write to addr 12 changes nothing.
- Object DMA:
  - Setup: obj_base=0x9000, LVBL falls, busack returned after 5 clks, vram_ok 2 clks after each cs.
  - First vram_addr = 0x0000 (0x9000[9:0]=0).
  - Exactly 1024 buf_we pulses with buf_sel=0 and buf_addr 0..1023.
  - busreq drops after the last word.
- Palette while object DMA runs: write pal_base=0x9014 mid-transfer.
  - The object copy completes unaffected.
  - busreq low ≥1 clk, then the palette transfer starts at vram_addr 0x0A00.
  - 3072 pulses with buf_sel=1.
- Stale ok: hold vram_ok high constantly → one word per ADDR+WAIT pair (2 clks per word), with data captured from each new address.
- Grant drop: drop busack for 10 clks mid-transfer → vram_cs=0 during the gap, then the copy resumes at the same cnt. The buffer contents equal the source, checked against a scoreboard.
